// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/op input handshake and result output handshake
// of the execute-stage ALU. The unit connects through the slave modport and
// the upstream/downstream side through the master modport.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, alu_result, zero
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, alu_result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a registered result behind a
// valid/ready handshake. ADD/SUB/AND/OR/XOR/SLT finish in one cycle; SLL/SRL
// use an iterative 1-bit/cycle shifter (latency shamt+1).
// Optional macro FAST_SHIFT_EN: SLL/SRL use a combinational barrel shifter
// and finish in one cycle; the SHIFT state is never entered and busy is 0.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus,
    output logic           busy
);

`ifdef FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               shr_q, shr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;

    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               accept;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   shift_next;
    logic [WIDTH-1:0]   load_val;
    logic               load;

    assign bus.in_ready   = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign accept         = bus.in_valid && bus.in_ready;

`ifdef FAST_SHIFT_EN
    assign busy = 1'b0;
`else
    assign busy = (state_q == S_SHIFT);
`endif

    // Decode the incoming op and compute its one-cycle result.
    always_comb begin
        op         = alu_op_e'(bus.alu_control);
        shamt      = bus.src_b[SHAMT_W-1:0];
        is_shift   = (op == OP_SLL) || (op == OP_SRL);
        single_res = '0;
        case (op)
            OP_ADD:  single_res = bus.src_a + bus.src_b;
            OP_SUB:  single_res = bus.src_a - bus.src_b;
            OP_AND:  single_res = bus.src_a & bus.src_b;
            OP_OR:   single_res = bus.src_a | bus.src_b;
            OP_XOR:  single_res = bus.src_a ^ bus.src_b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            // Iterative build only reaches here with shamt==0, where the result is src_a.
            OP_SLL:  single_res = FAST_SHIFT ? (bus.src_a << shamt) : bus.src_a;
            OP_SRL:  single_res = FAST_SHIFT ? (bus.src_a >> shamt) : bus.src_a;
            default: single_res = '0;
        endcase
    end

    // Next-state logic: FSM, iterative shifter and output register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        shr_d       = shr_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        load        = 1'b0;
        load_val    = '0;
        shift_next  = shr_q ? (shreg_q >> 1) : (shreg_q << 1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!FAST_SHIFT && is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        cnt_d   = shamt;
                        shreg_d = bus.src_a;
                        shr_d   = (op == OP_SRL);
                    end else begin
                        load     = 1'b1;
                        load_val = single_res;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = shift_next;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    // Last shift step: entry to SHIFT guaranteed the output slot is free.
                    load     = 1'b1;
                    load_val = shift_next;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            result_d    = load_val;
            zero_d      = (load_val == '0);
            out_valid_d = 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    // Shift datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: no reset needed; contents are only used in SHIFT, which always loads them on entry.
        shreg_q <= shreg_d;
        shr_q   <= shr_d;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed, table-driven bench for alu_exec_unit.
// Build with +define+FAST_SHIFT_EN to check the barrel-shifter variant.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SLT = 3'b101;
    localparam logic [2:0] SLL = 3'b110;
    localparam logic [2:0] SRL = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[12];

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
    endtask

    // Issue one shift at a negedge and measure latency, busy cycles and result.
    task automatic run_shift(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cyc;
        int ready_bad;
        logic [31:0] res;
        lat = 0; busy_cyc = 0; ready_bad = 0; res = '0;
        bus.out_ready = 1'b1;
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(op, a, b);
        for (int c = 1; c <= WIDTH + 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.in_valid = 1'b0;
            if (busy) begin
                busy_cyc++;
                if (bus.in_ready) ready_bad++;
            end
            if (bus.out_valid && lat == 0) begin
                lat = c;
                res = bus.alu_result;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
        check({name, " in_ready while busy"}, 32'(ready_bad), 32'd0);
        check({name, " result"}, res, exp);
    endtask

    initial begin
        vecs[0]  = '{ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{SUB, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000};
        vecs[2]  = '{SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4]  = '{AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[5]  = '{OR,  32'hA000_0005, 32'h0500_0A00, 32'hA500_0A05};
        vecs[6]  = '{XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vecs[7]  = '{ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[8]  = '{SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[9]  = '{SRL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF};
        vecs[10] = '{SLL, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[11] = '{SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_control = ADD;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset alu_result", bus.alu_result, 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming single-cycle ops back to back
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                check($sformatf("vec%0d out_valid", i - 1), 32'(bus.out_valid), 32'd1);
                check($sformatf("vec%0d result", i - 1), bus.alu_result, vecs[i-1].exp);
                check($sformatf("vec%0d zero", i - 1), 32'(bus.zero), 32'(vecs[i-1].exp == 32'd0));
            end
            if (i < 12) begin
                check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
                drive(vecs[i].op, vecs[i].a, vecs[i].b);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream drain out_valid", 32'(bus.out_valid), 32'd0);

        // Shifts: long, direction, minimum shamt
`ifdef FAST_SHIFT_EN
        run_shift("sll31", SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 1);
        run_shift("srl4",  SRL, 32'h8000_0000, 32'd4,  32'h0800_0000, 1);
        run_shift("sll1",  SLL, 32'h8000_0001, 32'd1,  32'h0000_0002, 1);
`else
        run_shift("sll31", SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 32);
        run_shift("srl4",  SRL, 32'h8000_0000, 32'd4,  32'h0800_0000, 5);
        run_shift("sll1",  SLL, 32'h8000_0001, 32'd1,  32'h0000_0002, 2);
`endif

        // Backpressure hold, then drain + accept in the same cycle
        bus.out_ready = 1'b0;
        drive(AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) drive(OR, 32'h0F00_0000, 32'h0000_00F0);
            check($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d result", k), bus.alu_result, 32'h0F00_0F00);
            check($sformatf("hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("drain+accept in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("drain+accept out_valid", 32'(bus.out_valid), 32'd1);
        check("drain+accept result", bus.alu_result, 32'h0F00_00F0);
        @(negedge clk);
        check("post drain out_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of an SRL
        begin
            int valid_seen;
            valid_seen = 0;
            drive(SRL, 32'hF000_0000, 32'd20);
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (c == 1) bus.in_valid = 1'b0;
                if (bus.out_valid) valid_seen++;
                if (c == 10) begin
`ifdef FAST_SHIFT_EN
                    check("mid-shift busy", 32'(busy), 32'd0);
`else
                    check("mid-shift busy", 32'(busy), 32'd1);
`endif
                    rst = 1'b1;
                end
                if (c == 11) begin
                    rst = 1'b0;
                    check("post-reset busy", 32'(busy), 32'd0);
                    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
                end
            end
`ifdef FAST_SHIFT_EN
            check("reset-shift out_valid cycles", 32'(valid_seen), 32'd1);
`else
            check("reset-shift out_valid cycles", 32'(valid_seen), 32'd0);
`endif
        end
        drive(ADD, 32'd5, 32'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("post-reset add out_valid", 32'(bus.out_valid), 32'd1);
        check("post-reset add result", bus.alu_result, 32'd12);
        check("post-reset add zero", 32'(bus.zero), 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
